// File: rtl/tmds_decoder_if.sv
// Signal bundle between a channel deserializer and its TMDS decoder.
// The slave modport is the decoder view; master is the deserializer/consumer view.
interface tmds_decoder_if;
    logic [9:0] pi_word;
    logic       pi_word_valid;
    logic [7:0] po_data;
    logic [1:0] po_ctrl;
    logic       po_de;
    logic       po_valid;
    logic       po_locked;
    logic [3:0] po_offset;

    modport master (
        output pi_word,
        output pi_word_valid,
        input  po_data,
        input  po_ctrl,
        input  po_de,
        input  po_valid,
        input  po_locked,
        input  po_offset
    );

    modport slave (
        input  pi_word,
        input  pi_word_valid,
        output po_data,
        output po_ctrl,
        output po_de,
        output po_valid,
        output po_locked,
        output po_offset
    );
endinterface

// File: rtl/tmds_decoder.sv
// Per-channel TMDS receive decoder: bit-slip alignment on control tokens,
// then a two-stage pipeline (window select + token match, decode register).
module tmds_decoder #(
    parameter int LOCK_COUNT    = 16,
    parameter int SEARCH_WINDOW = 2048,
    parameter int LOSS_WINDOW   = 2048
) (
    input  logic          pi_clk,
    input  logic          pi_rst,
    tmds_decoder_if.slave bus
);
    localparam int RUN_W    = $clog2(LOCK_COUNT) + 1;
    localparam int IDLE_MAX = (SEARCH_WINDOW > LOSS_WINDOW) ? SEARCH_WINDOW : LOSS_WINDOW;
    localparam int IDLE_W   = $clog2(IDLE_MAX) + 1;

    localparam logic [RUN_W-1:0]  RUN_LIMIT    = RUN_W'(LOCK_COUNT);
    localparam logic [IDLE_W-1:0] SEARCH_LIMIT = IDLE_W'(SEARCH_WINDOW);
    localparam logic [IDLE_W-1:0] LOSS_LIMIT   = IDLE_W'(LOSS_WINDOW);
    localparam logic [3:0]        OFFSET_MAX   = 4'd9;

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Returns {is_token, ctrl}; anything that is not one of the four tokens is data.
    function automatic logic [2:0] match_token(input logic [9:0] sym);
        logic [2:0] res;
        case (sym)
            10'b1101010100: res = {1'b1, 2'b00};
            10'b0010101011: res = {1'b1, 2'b01};
            10'b0101010100: res = {1'b1, 2'b10};
            10'b1010101011: res = {1'b1, 2'b11};
            default:        res = {1'b0, 2'b00};
        endcase
        return res;
    endfunction

    function automatic logic [7:0] decode_data(input logic [9:0] sym);
        logic [7:0] d;
        logic [7:0] res;
        d      = sym[9] ? ~sym[7:0] : sym[7:0];
        res    = 8'h00;
        res[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            if (sym[8]) begin
                res[i] = d[i] ^ d[i-1];
            end else begin
                res[i] = ~(d[i] ^ d[i-1]);
            end
        end
        return res;
    endfunction

    state_t              state_q, state_d;
    logic [3:0]          offset_q, offset_d;
    logic [RUN_W-1:0]    run_cnt_q, run_cnt_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [9:0]          prev_q, prev_d;
    logic [9:0]          s1_sym_q, s1_sym_d;
    logic                s1_tok_q, s1_tok_d;
    logic [1:0]          s1_ctrl_q, s1_ctrl_d;
    logic                s1_valid_q, s1_valid_d;
    logic [7:0]          data_q, data_d;
    logic [1:0]          ctrl_q, ctrl_d;
    logic                de_q, de_d;
    logic                valid_q, valid_d;

    logic [19:0]         win_cat;
    logic [9:0]          win_sym;
    logic [2:0]          win_tok;
    logic [RUN_W-1:0]    run_inc;
    logic [IDLE_W-1:0]   idle_inc;

    // Symbol window straddling the previous and current word at the slip offset.
    always_comb begin
        win_cat  = {bus.pi_word, prev_q};
        win_sym  = 10'(win_cat >> offset_q);
        win_tok  = match_token(win_sym);
        run_inc  = run_cnt_q + RUN_W'(1);
        idle_inc = idle_cnt_q + IDLE_W'(1);
    end

    // Alignment FSM next state and stage-1 capture; matching always uses the old offset.
    always_comb begin
        state_d    = state_q;
        offset_d   = offset_q;
        run_cnt_d  = run_cnt_q;
        idle_cnt_d = idle_cnt_q;
        prev_d     = prev_q;
        s1_sym_d   = s1_sym_q;
        s1_tok_d   = s1_tok_q;
        s1_ctrl_d  = s1_ctrl_q;
        s1_valid_d = 1'b0;
        if (bus.pi_word_valid) begin
            prev_d     = bus.pi_word;
            s1_sym_d   = win_sym;
            s1_tok_d   = win_tok[2];
            s1_ctrl_d  = win_tok[1:0];
            s1_valid_d = (state_q == ST_LOCKED);
            case (state_q)
                ST_SEARCH: begin
                    if (win_tok[2]) begin
                        if (run_inc == RUN_LIMIT) begin
                            state_d    = ST_LOCKED;
                            run_cnt_d  = {RUN_W{1'b0}};
                            idle_cnt_d = {IDLE_W{1'b0}};
                        end else begin
                            run_cnt_d  = run_inc;
                            idle_cnt_d = {IDLE_W{1'b0}};
                        end
                    end else if (idle_inc == SEARCH_LIMIT) begin
                        offset_d   = (offset_q == OFFSET_MAX) ? 4'd0 : offset_q + 4'd1;
                        run_cnt_d  = {RUN_W{1'b0}};
                        idle_cnt_d = {IDLE_W{1'b0}};
                    end else begin
                        run_cnt_d  = {RUN_W{1'b0}};
                        idle_cnt_d = idle_inc;
                    end
                end
                ST_LOCKED: begin
                    if (win_tok[2]) begin
                        idle_cnt_d = {IDLE_W{1'b0}};
                    end else if (idle_inc == LOSS_LIMIT) begin
                        state_d    = ST_SEARCH;
                        run_cnt_d  = {RUN_W{1'b0}};
                        idle_cnt_d = {IDLE_W{1'b0}};
                    end else begin
                        idle_cnt_d = idle_inc;
                    end
                end
                default: begin
                    state_d    = ST_SEARCH;
                    run_cnt_d  = {RUN_W{1'b0}};
                    idle_cnt_d = {IDLE_W{1'b0}};
                end
            endcase
        end else begin
            s1_valid_d = 1'b0;
        end
    end

    // Stage 2: decode only symbols captured while locked; otherwise hold the outputs.
    always_comb begin
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        de_d    = de_q;
        valid_d = s1_valid_q;
        if (s1_valid_q) begin
            if (s1_tok_q) begin
                de_d   = 1'b0;
                ctrl_d = s1_ctrl_q;
            end else begin
                de_d   = 1'b1;
                data_d = decode_data(s1_sym_q);
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    // State, counters and both pipeline stages; reset discards everything in flight.
    always_ff @(posedge pi_clk) begin
        if (pi_rst) begin
            state_q    <= ST_SEARCH;
            offset_q   <= 4'd0;
            run_cnt_q  <= {RUN_W{1'b0}};
            idle_cnt_q <= {IDLE_W{1'b0}};
            prev_q     <= 10'd0;
            s1_sym_q   <= 10'd0;
            s1_tok_q   <= 1'b0;
            s1_ctrl_q  <= 2'b00;
            s1_valid_q <= 1'b0;
            data_q     <= 8'h00;
            ctrl_q     <= 2'b00;
            de_q       <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            offset_q   <= offset_d;
            run_cnt_q  <= run_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            prev_q     <= prev_d;
            s1_sym_q   <= s1_sym_d;
            s1_tok_q   <= s1_tok_d;
            s1_ctrl_q  <= s1_ctrl_d;
            s1_valid_q <= s1_valid_d;
            data_q     <= data_d;
            ctrl_q     <= ctrl_d;
            de_q       <= de_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.po_data   = data_q;
    assign bus.po_ctrl   = ctrl_q;
    assign bus.po_de     = de_q;
    assign bus.po_valid  = valid_q;
    assign bus.po_locked = (state_q == ST_LOCKED);
    assign bus.po_offset = offset_q;
endmodule

// File: tb/tb_tmds_decoder.sv
// Randomized bench for tmds_decoder: a serial-bitstream source feeds the DUT and a
// reference model built from the encoder rules predicts lock, offset and decoded output.
module tb_tmds_decoder;
    localparam int LOCK_COUNT = 16;
    localparam int SEARCH_WIN = 8;
    localparam int LOSS_WIN   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    tmds_decoder_if bus_if ();

    tmds_decoder #(
        .LOCK_COUNT   (LOCK_COUNT),
        .SEARCH_WINDOW(SEARCH_WIN),
        .LOSS_WINDOW  (LOSS_WIN)
    ) dut (
        .pi_clk(clk),
        .pi_rst(rst),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] dec_tab [1024];
    logic [9:0] toks [4];
    bit         bitq [$];
    bit         gap_mode = 1'b0;

    // reference model state
    bit         m_locked;
    int         m_offset, m_run, m_idle;
    logic [9:0] m_prev;
    bit         p1_valid, p1_de, e_valid, e_de;
    logic [7:0] p1_data, e_data;
    logic [1:0] p1_ctrl, e_ctrl;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_token(input logic [9:0] s);
        int res;
        res = -1;
        for (int k = 0; k < 4; k++) begin
            if (s == toks[k]) res = k;
        end
        return res;
    endfunction

    // Decode table obtained by running the transmitter encoder over every byte/choice.
    task automatic build_table();
        logic [7:0] dd, qm;
        logic [9:0] sym;
        for (int d = 0; d < 256; d++) begin
            for (int x = 0; x < 2; x++) begin
                for (int inv = 0; inv < 2; inv++) begin
                    dd    = d[7:0];
                    qm[0] = dd[0];
                    for (int i = 1; i < 8; i++)
                        qm[i] = (x == 1) ? (qm[i-1] ^ dd[i]) : ~(qm[i-1] ^ dd[i]);
                    sym = {inv[0], x[0], (inv == 1) ? ~qm : qm};
                    dec_tab[sym] = dd;
                end
            end
        end
    endtask

    task automatic model_edge(input logic [9:0] w, input bit v, input bit r);
        logic [19:0] cat;
        logic [9:0]  sym;
        int          tk;
        if (r) begin
            m_locked = 1'b0; m_offset = 0; m_run = 0; m_idle = 0; m_prev = 10'd0;
            p1_valid = 1'b0; e_valid = 1'b0;
        end else begin
            e_valid = p1_valid; e_de = p1_de; e_data = p1_data; e_ctrl = p1_ctrl;
            p1_valid = 1'b0;
            if (v) begin
                cat = {w, m_prev};
                cat = cat >> m_offset;
                sym = cat[9:0];
                tk  = ref_token(sym);
                if (m_locked) begin
                    p1_valid = 1'b1;
                    p1_de    = (tk < 0);
                    p1_data  = dec_tab[sym];
                    p1_ctrl  = tk[1:0];
                end
                if (!m_locked) begin
                    if (tk >= 0) begin
                        m_run++; m_idle = 0;
                        if (m_run == LOCK_COUNT) begin m_locked = 1'b1; m_run = 0; end
                    end else begin
                        m_run = 0; m_idle++;
                        if (m_idle == SEARCH_WIN) begin m_offset = (m_offset + 1) % 10; m_idle = 0; end
                    end
                end else begin
                    if (tk >= 0) m_idle = 0;
                    else begin
                        m_idle++;
                        if (m_idle == LOSS_WIN) begin m_locked = 1'b0; m_idle = 0; m_run = 0; end
                    end
                end
                m_prev = w;
            end
        end
    endtask

    task automatic step(input logic [9:0] w, input bit v, input bit r);
        bus_if.pi_word       = w;
        bus_if.pi_word_valid = v;
        rst                  = r;
        model_edge(w, v, r);
        @(posedge clk);
        #1;
        check_eq("po_valid",  32'(bus_if.po_valid),  32'(e_valid));
        check_eq("po_locked", 32'(bus_if.po_locked), 32'(m_locked));
        check_eq("po_offset", 32'(bus_if.po_offset), 32'(m_offset));
        if (e_valid) begin
            check_eq("po_de", 32'(bus_if.po_de), 32'(e_de));
            if (e_de) check_eq("po_data", 32'(bus_if.po_data), 32'(e_data));
            else      check_eq("po_ctrl", 32'(bus_if.po_ctrl), 32'(e_ctrl));
        end
    endtask

    // Serialize one symbol (bit 0 first) and emit every complete 10-bit word.
    task automatic tx_sym(input logic [9:0] s);
        logic [9:0] w;
        for (int i = 0; i < 10; i++) bitq.push_back(s[i]);
        while (bitq.size() >= 10) begin
            for (int i = 0; i < 10; i++) w[i] = bitq.pop_front();
            step(w, 1'b1, 1'b0);
            if (gap_mode) step(10'($urandom), 1'b0, 1'b0);
        end
    endtask

    task automatic tx_align(input int pad);
        bitq.delete();
        for (int i = 0; i < pad; i++) bitq.push_back(1'b0);
    endtask

    function automatic logic [9:0] rand_data_sym();
        logic [9:0] s;
        s = 10'($urandom);
        while (ref_token(s) >= 0) s = 10'($urandom);
        return s;
    endfunction

    task automatic check_zero(input string tag);
        check_eq({tag, "_data"},   32'(bus_if.po_data),   32'd0);
        check_eq({tag, "_ctrl"},   32'(bus_if.po_ctrl),   32'd0);
        check_eq({tag, "_de"},     32'(bus_if.po_de),     32'd0);
        check_eq({tag, "_valid"},  32'(bus_if.po_valid),  32'd0);
        check_eq({tag, "_locked"}, 32'(bus_if.po_locked), 32'd0);
        check_eq({tag, "_offset"}, 32'(bus_if.po_offset), 32'd0);
    endtask

    initial begin
        toks[0] = 10'b1101010100;
        toks[1] = 10'b0010101011;
        toks[2] = 10'b0101010100;
        toks[3] = 10'b1010101011;
        build_table();

        repeat (3) step(10'd0, 1'b0, 1'b1);
        check_zero("reset");

        // aligned stream at offset 0, then decode of specific symbols
        tx_align(0);
        repeat (20) tx_sym(toks[0]);
        tx_sym(10'b0100000000);
        tx_sym(10'b1011111111);
        tx_sym(toks[1]);
        tx_sym(toks[3]);
        repeat (3) step(10'($urandom), 1'b0, 1'b0);
        check_eq("aligned_locked", 32'(bus_if.po_locked), 32'd1);
        check_eq("aligned_offset", 32'(bus_if.po_offset), 32'd0);

        // stream misaligned by 3 bits, then loss of lock
        repeat (2) step(10'd0, 1'b0, 1'b1);
        tx_align(3);
        repeat (50) tx_sym(toks[0]);
        check_eq("mis_locked", 32'(bus_if.po_locked), 32'd1);
        check_eq("mis_offset", 32'(bus_if.po_offset), 32'd3);
        repeat (LOSS_WIN + 1) tx_sym(rand_data_sym());
        check_eq("loss_locked", 32'(bus_if.po_locked), 32'd0);
        check_eq("loss_offset", 32'(bus_if.po_offset), 32'd3);
        repeat (3) step(10'($urandom), 1'b0, 1'b0);

        // relock and random data/token mix at offset 3
        repeat (20) tx_sym(toks[2]);
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 3) == 0) tx_sym(toks[$urandom_range(0, 3)]);
            else tx_sym(rand_data_sym());
        end

        // wrap-around: walk the offset to 9 on idle words, then tokens aligned at 0
        repeat (2) step(10'd0, 1'b0, 1'b1);
        tx_align(0);
        repeat (9 * SEARCH_WIN) tx_sym(10'd0);
        check_eq("wrap_offset9", 32'(bus_if.po_offset), 32'd9);
        repeat (30) tx_sym(toks[0]);
        check_eq("wrap_offset0", 32'(bus_if.po_offset), 32'd0);
        check_eq("wrap_locked",  32'(bus_if.po_locked), 32'd1);

        // valid gaps every other cycle with a reset in the middle of the search
        repeat (2) step(10'd0, 1'b0, 1'b1);
        gap_mode = 1'b1;
        tx_align(0);
        repeat (10) tx_sym(toks[0]);
        step(toks[0], 1'b1, 1'b1);
        check_zero("midrst");
        repeat (20) tx_sym(toks[1]);
        check_eq("gap_locked", 32'(bus_if.po_locked), 32'd1);
        gap_mode = 1'b0;

        // raw random words, random valid and occasional reset
        for (int n = 0; n < 300; n++)
            step(10'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
